block_transfer_unit: RTL and testbench

Load/store-multiple sequencer (ARM LDM/STM style) on the initiator side of the data-memory port. Accepts one block-transfer request from the core, walks the 16-bit register list, and performs one word transfer per cycle by driving address/writeData/MemRead/MemWrite into the data memory. It moves words between the data memory and the register file, and returns the writeback base address. It sits between the execute stage and the data memory.

---
 rtl/block_xfer_pkg.sv | 24 ++
 rtl/block_transfer_unit_if.sv | 51 +++++
 rtl/lowest_set_bit.sv | 23 ++
 rtl/block_transfer_unit.sv | 149 ++++++++++++++
 tb/tb_block_transfer_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_xfer_pkg.sv
// Shared types and sizes for the load/store-multiple sequencer.
// Holds the FSM encoding, addressing-mode codes and bus widths.
package block_xfer_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int NREG       = 16;
    localparam int DMEM_DEPTH = 16;
    localparam int IDX_W      = $clog2(NREG);
    localparam int CNT_W      = $clog2(NREG + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        DONE
    } xferState_e;

    localparam logic [1:0] MODE_IA = 2'd0;
    localparam logic [1:0] MODE_IB = 2'd1;
    localparam logic [1:0] MODE_DA = 2'd2;
    localparam logic [1:0] MODE_DB = 2'd3;

endpackage

// File: rtl/block_transfer_unit_if.sv
// Bus bundle of the block-transfer unit: request handshake,
// register-file read/write ports, data-memory port, completion.
// slave  = the sequencer; master = core/memory/register-file side.
interface block_transfer_unit_if;
    import block_xfer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [1:0]        req_mode;
    logic [ADDR_W-1:0] req_base;
    logic [NREG-1:0]   req_reglist;

    logic [IDX_W-1:0]  rf_rd_idx;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_wr_idx;
    logic [DATA_W-1:0] rf_wr_data;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              MemWrite;
    logic              MemRead;

    logic              done;
    logic [ADDR_W-1:0] final_addr;

    modport slave (
        input  req_valid, req_load, req_mode,
        input  req_base, req_reglist,
        input  rf_rd_data, readData,
        output req_ready, rf_rd_idx, rf_we,
        output rf_wr_idx, rf_wr_data,
        output address, writeData,
        output MemWrite, MemRead,
        output done, final_addr
    );

    modport master (
        output req_valid, req_load, req_mode,
        output req_base, req_reglist,
        output rf_rd_data, readData,
        input  req_ready, rf_rd_idx, rf_we,
        input  rf_wr_idx, rf_wr_data,
        input  address, writeData,
        input  MemWrite, MemRead,
        input  done, final_addr
    );

endinterface

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of vec.
// Ports: vec (in), idx (out, 0 when empty), any (out, vec != 0).
module lowest_set_bit
    import block_xfer_pkg::*;
(
    input  logic [NREG-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan downward so the lowest set bit is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_transfer_unit.sv
// LDM/STM sequencer: one word per cycle between data memory
// and register file. Ports: clk, reset (async, active-high),
// bus (slave modport: request, rf ports, memory port, done).
module block_transfer_unit
    import block_xfer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    block_transfer_unit_if.slave bus
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    xferState_e        state;
    xferState_e        nextState;

    logic              load;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base;
    logic [NREG-1:0]   mask;
    logic [ADDR_W-1:0] curAddr;
    logic [ADDR_W-1:0] finalAddr;

    logic [IDX_W-1:0]  lsbIdx;
    logic              maskAny;
    logic [NREG-1:0]   nextMask;
    logic [CNT_W-1:0]  setCount;
    logic [ADDR_W-1:0] nAddr;
    logic [ADDR_W-1:0] startAddr;
    logic [ADDR_W-1:0] endAddr;

    lowest_set_bit uLsb (
        .vec (mask),
        .idx (lsbIdx),
        .any (maskAny)
    );

    assign nextMask = mask & ~(NREG'(1) << lsbIdx);

    always_comb begin
        setCount = '0;
        for (int i = 0; i < NREG; i++) begin
            setCount = setCount + CNT_W'(mask[i]);
        end
    end

    assign nAddr = ADDR_W'(setCount);

    // Lowest register always lands on the lowest address, so
    // the decrementing modes start n-1 or n words below base.
    always_comb begin
        startAddr = base;
        unique case (mode)
            MODE_IA: startAddr = base;
            MODE_IB: startAddr = base + ONE;
            MODE_DA: startAddr = base - nAddr + ONE;
            MODE_DB: startAddr = base - nAddr;
        endcase
    end

    assign endAddr = (mode == MODE_IA || mode == MODE_IB)
                   ? base + nAddr
                   : base - nAddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load      <= 1'b0;
            mode      <= MODE_IA;
            base      <= '0;
            mask      <= '0;
            curAddr   <= '0;
            finalAddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        load <= bus.req_load;
                        mode <= bus.req_mode;
                        base <= bus.req_base;
                        mask <= bus.req_reglist;
                    end
                end
                SETUP: begin
                    curAddr   <= startAddr;
                    finalAddr <= endAddr;
                end
                XFER: begin
                    mask    <= nextMask;
                    curAddr <= curAddr + ONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from the state register only, so strobes
    // are stable for the whole cycle and zero outside XFER.
    always_comb begin
        nextState      = state;
        bus.req_ready  = 1'b0;
        bus.rf_rd_idx  = '0;
        bus.rf_we      = 1'b0;
        bus.rf_wr_idx  = '0;
        bus.rf_wr_data = '0;
        bus.address    = '0;
        bus.writeData  = '0;
        bus.MemWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.done       = 1'b0;
        bus.final_addr = '0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) nextState = SETUP;
            end
            SETUP: begin
                nextState = maskAny ? XFER : DONE;
            end
            XFER: begin
                bus.address = curAddr;
                if (load) begin
                    bus.MemRead    = 1'b1;
                    bus.rf_we      = 1'b1;
                    bus.rf_wr_idx  = lsbIdx;
                    bus.rf_wr_data = bus.readData;
                end else begin
                    bus.rf_rd_idx = lsbIdx;
                    bus.writeData = bus.rf_rd_data;
                    bus.MemWrite  = 1'b1;
                end
                if (nextMask == '0) nextState = DONE;
            end
            DONE: begin
                bus.done       = 1'b1;
                bus.final_addr = finalAddr;
                nextState      = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_block_transfer_unit.sv
// Randomized bench for block_transfer_unit against a
// transaction-level model of memory and register-file images.
module tb_block_transfer_unit;
    import block_xfer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    block_transfer_unit_if bus ();

    block_transfer_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem    [DMEM_DEPTH];
    logic [DATA_W-1:0] rf     [NREG];
    logic [DATA_W-1:0] refMem [DMEM_DEPTH];
    logic [DATA_W-1:0] refRf  [NREG];

    assign bus.rf_rd_data = rf[bus.rf_rd_idx];
    assign bus.readData   = mem[int'(bus.address) % DMEM_DEPTH];

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkEq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h",
                     tag, got, exp);
        end
    endtask

    function automatic int memIdx(input logic [ADDR_W-1:0] a);
        return int'(a) % DMEM_DEPTH;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkEq({tag, "/ready"}, 32'(bus.req_ready), 1);
        checkEq({tag, "/strobes"},
                32'({bus.MemRead, bus.MemWrite,
                     bus.rf_we, bus.done}), 0);
        checkEq({tag, "/address"}, 32'(bus.address), 0);
        checkEq({tag, "/writeData"}, 32'(bus.writeData), 0);
        checkEq({tag, "/rfIdx"},
                32'({bus.rf_rd_idx, bus.rf_wr_idx}), 0);
        checkEq({tag, "/rfWrData"}, 32'(bus.rf_wr_data), 0);
        checkEq({tag, "/finalAddr"}, 32'(bus.final_addr), 0);
    endtask

    task automatic checkImages(input string tag);
        int diffs = 0;
        for (int i = 0; i < DMEM_DEPTH; i++)
            if (mem[i] !== refMem[i]) diffs++;
        for (int i = 0; i < NREG; i++)
            if (rf[i] !== refRf[i]) diffs++;
        checkEq({tag, "/images"}, diffs, 0);
    endtask

    task automatic driveJunk();
        bus.req_valid   = 1'($urandom);
        bus.req_load    = 1'($urandom);
        bus.req_mode    = 2'($urandom);
        bus.req_base    = ADDR_W'($urandom);
        bus.req_reglist = NREG'($urandom);
    endtask

    // abortAfter > 0: reset is raised during the beat after that
    // many completed transfers.
    task automatic runTxn(input string name,
                          input bit ld,
                          input logic [1:0] md,
                          input logic [ADDR_W-1:0] base,
                          input logic [NREG-1:0] list,
                          input int abortAfter);
        int n;
        int regs[$];
        int modelBeats;
        logic [ADDR_W-1:0] lowAddr;
        logic [ADDR_W-1:0] finalExp;
        logic [ADDR_W-1:0] a;
        int beats;
        int stray;
        int doneCyc;
        int k;
        bit fin;
        int quiet;

        n = $countones(list);
        for (int i = 0; i < NREG; i++)
            if (list[i]) regs.push_back(i);

        case (md)
            MODE_IA: lowAddr = base;
            MODE_IB: lowAddr = base + 1'b1;
            MODE_DA: lowAddr = base - ADDR_W'(n) + 1'b1;
            default: lowAddr = base - ADDR_W'(n);
        endcase
        finalExp = (md < 2) ? base + ADDR_W'(n)
                            : base - ADDR_W'(n);

        modelBeats = (abortAfter > 0) ? abortAfter : n;
        for (int b = 0; b < modelBeats; b++) begin
            a = lowAddr + ADDR_W'(b);
            if (ld) refRf[regs[b]] = refMem[memIdx(a)];
            else    refMem[memIdx(a)] = refRf[regs[b]];
        end

        @(negedge clk);
        checkEq({name, "/readyIn"}, 32'(bus.req_ready), 1);
        bus.req_valid   = 1'b1;
        bus.req_load    = ld;
        bus.req_mode    = md;
        bus.req_base    = base;
        bus.req_reglist = list;
        @(posedge clk);

        beats   = 0;
        stray   = 0;
        doneCyc = -1;
        k       = 0;
        fin     = 1'b0;
        while (!fin && k < n + 8) begin
            k++;
            @(negedge clk);
            if (bus.MemRead || bus.MemWrite || bus.rf_we) begin
                if (beats < n) begin
                    a = lowAddr + ADDR_W'(beats);
                    checkEq({name, "/beatCycle"}, k, beats + 2);
                    checkEq({name, "/address"},
                            32'(bus.address), 32'(a));
                    checkEq({name, "/strobes"},
                            32'({bus.MemRead, bus.MemWrite,
                                 bus.rf_we}),
                            ld ? 32'b101 : 32'b010);
                    if (ld) begin
                        checkEq({name, "/wrIdx"},
                                32'(bus.rf_wr_idx), regs[beats]);
                        checkEq({name, "/wrData"},
                                32'(bus.rf_wr_data),
                                32'(refMem[memIdx(a)]));
                        if (bus.rf_we)
                            rf[bus.rf_wr_idx] = bus.rf_wr_data;
                    end else begin
                        checkEq({name, "/writeData"},
                                32'(bus.writeData),
                                32'(refRf[regs[beats]]));
                        if (bus.MemWrite)
                            mem[memIdx(bus.address)] = bus.writeData;
                    end
                end else begin
                    stray++;
                end
                beats++;
            end
            if (bus.done && doneCyc < 0) begin
                doneCyc = k;
                checkEq({name, "/finalAddr"},
                        32'(bus.final_addr), 32'(finalExp));
            end
            if (doneCyc >= 0 && k == doneCyc + 1) begin
                checkEq({name, "/readyBack"},
                        32'(bus.req_ready), 1);
                fin = 1'b1;
            end
            if (k <= n + 1) driveJunk();
            else bus.req_valid = 1'b0;

            if (abortAfter > 0 && beats == abortAfter) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                reset = 1'b1;
                #1;
                checkEq({name, "/strobeDrop"},
                        32'({bus.MemRead, bus.MemWrite,
                             bus.rf_we, bus.done}), 0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                quiet = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.done || bus.MemWrite ||
                        bus.MemRead || bus.rf_we)
                        quiet++;
                end
                checkEq({name, "/noDone"}, quiet, 0);
                checkEq({name, "/readyAfter"},
                        32'(bus.req_ready), 1);
                checkEq({name, "/writes"}, beats, abortAfter);
                checkImages(name);
                return;
            end
        end
        bus.req_valid = 1'b0;

        checkEq({name, "/beats"}, beats, n);
        checkEq({name, "/stray"}, stray, 0);
        checkEq({name, "/doneCycle"}, doneCyc, n + 2);
        checkImages(name);
    endtask

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_load    = 1'b0;
        bus.req_mode    = MODE_IA;
        bus.req_base    = '0;
        bus.req_reglist = '0;
        for (int i = 0; i < DMEM_DEPTH; i++) begin
            mem[i]    = DATA_W'($urandom);
            refMem[i] = mem[i];
        end
        for (int i = 0; i < NREG; i++) begin
            rf[i]    = DATA_W'($urandom);
            refRf[i] = rf[i];
        end

        #1;
        checkIdleOutputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        rf[0] = 16'h1111; refRf[0] = 16'h1111;
        rf[1] = 16'h2222; refRf[1] = 16'h2222;
        rf[3] = 16'h3333; refRf[3] = 16'h3333;
        runTxn("stmIA", 1'b0, MODE_IA, 16'd4, 16'h000B, 0);
        checkEq("stmIA/mem4", 32'(mem[4]), 32'h1111);
        checkEq("stmIA/mem6", 32'(mem[6]), 32'h3333);

        mem[6] = 16'h00AA; refMem[6] = 16'h00AA;
        mem[7] = 16'h00BB; refMem[7] = 16'h00BB;
        runTxn("ldmDB", 1'b1, MODE_DB, 16'd8, 16'h8001, 0);
        checkEq("ldmDB/r0", 32'(rf[0]), 32'h00AA);
        checkEq("ldmDB/r15", 32'(rf[15]), 32'h00BB);

        runTxn("empty", 1'b0, MODE_IA, 16'h0010, 16'h0000, 0);
        runTxn("wrap", 1'b0, MODE_IA, 16'hFFFF, 16'h0003, 0);
        runTxn("ldmIB", 1'b1, MODE_IB, 16'h0020, 16'h0C30, 0);
        runTxn("stmDA", 1'b0, MODE_DA, 16'h0001, 16'h0281, 0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        checkIdleOutputs("idleReset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkIdleOutputs("idleRelease");

        runTxn("abort", 1'b0, MODE_IA, 16'h0002, 16'h00F0, 2);

        for (int t = 0; t < 40; t++) begin
            logic [NREG-1:0] lst;
            case ($urandom_range(0, 3))
                0:       lst = '0;
                1:       lst = NREG'(1) << $urandom_range(0, 15);
                2:       lst = '1;
                default: lst = NREG'($urandom);
            endcase
            runTxn($sformatf("rnd%0d", t), 1'($urandom),
                   2'($urandom), ADDR_W'($urandom), lst, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
